// File: rtl/weight_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : weight_loader_pkg
//  Description : Shared lane/group geometry and loader state encoding,
//                common to the weight loader and the weight buffer.
//  Revision    : 1.0
// ============================================================================
package weight_loader_pkg;

    localparam int DATA_LEN_DEF     = 64;
    localparam int DDR_DATA_LEN_DEF = 256;
    localparam int BUFFER_NUM_DEF   = 8 * 16 * 16 / DATA_LEN_DEF;
    localparam int LANES            = DDR_DATA_LEN_DEF / DATA_LEN_DEF;
    localparam int GROUPS           = BUFFER_NUM_DEF / LANES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : weight_loader
//  Description : Turns a DDR beat stream into weight-buffer write strobes,
//                one group of LANES buffers per beat, GROUPS beats per line.
//  Revision    : 1.0
// ============================================================================
module weight_loader #(
    parameter int X_PE         = 16,
    parameter int X_MESH       = 16,
    parameter int ADDR_LEN     = 16,
    parameter int DATA_LEN     = 64,
    parameter int DDR_DATA_LEN = 256,
    parameter int BUFFER_NUM   = 8 * X_PE * X_MESH / DATA_LEN,
    parameter int LANES        = DDR_DATA_LEN / DATA_LEN,
    parameter int GROUPS       = BUFFER_NUM / LANES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_LEN-1:0]     st_wr_addr,
    input  logic [ADDR_LEN-1:0]     line_num,
    input  logic [DDR_DATA_LEN-1:0] ddr_data,
    input  logic                    ddr_valid,
    output logic                    ddr_ready,
    output logic [DDR_DATA_LEN-1:0] data_wr,
    output logic [ADDR_LEN-1:0]     wr_addr,
    output logic [BUFFER_NUM-1:0]   wr_en,
    output logic                    busy,
    output logic                    done
);

    import weight_loader_pkg::state_t;
    import weight_loader_pkg::IDLE;
    import weight_loader_pkg::LOAD;
    import weight_loader_pkg::DONE;

    localparam int                    GRP_W     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GRP_W-1:0]      GRP_LAST  = GRP_W'(GROUPS - 1);
    localparam logic [BUFFER_NUM-1:0] LANE_MASK = BUFFER_NUM'({LANES{1'b1}});

    state_t                  state_q, state_d;
    logic [GRP_W-1:0]        grp_q, grp_d;
    logic [ADDR_LEN-1:0]     cur_addr_q, cur_addr_d;
    logic [ADDR_LEN-1:0]     lines_left_q, lines_left_d;
    logic [DDR_DATA_LEN-1:0] data_wr_q, data_wr_d;
    logic [ADDR_LEN-1:0]     wr_addr_q, wr_addr_d;
    logic [BUFFER_NUM-1:0]   wr_en_q, wr_en_d;
    logic                    done_q, done_d;
    logic                    w_accept;

    assign ddr_ready = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign w_accept  = ddr_valid && ddr_ready;

    always_comb begin
        state_d      = state_q;
        grp_d        = grp_q;
        cur_addr_d   = cur_addr_q;
        lines_left_d = lines_left_q;
        data_wr_d    = data_wr_q;
        wr_addr_d    = wr_addr_q;
        wr_en_d      = '0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d   = st_wr_addr;
                    lines_left_d = line_num;
                    grp_d        = '0;
                    if (line_num == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (w_accept) begin
                    data_wr_d = ddr_data;
                    wr_addr_d = cur_addr_q;
                    wr_en_d   = LANE_MASK << (LANES * int'(grp_q));
                    // The last group of a line advances to the next address.
                    if (grp_q == GRP_LAST) begin
                        grp_d        = '0;
                        cur_addr_d   = cur_addr_q + ADDR_LEN'(1);
                        lines_left_d = lines_left_q - ADDR_LEN'(1);
                        if (lines_left_q == ADDR_LEN'(1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        grp_d = grp_q + GRP_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grp_q        <= '0;
            cur_addr_q   <= '0;
            lines_left_q <= '0;
            data_wr_q    <= '0;
            wr_addr_q    <= '0;
            wr_en_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grp_q        <= grp_d;
            cur_addr_q   <= cur_addr_d;
            lines_left_q <= lines_left_d;
            data_wr_q    <= data_wr_d;
            wr_addr_q    <= wr_addr_d;
            wr_en_q      <= wr_en_d;
            done_q       <= done_d;
        end
    end

    assign data_wr = data_wr_q;
    assign wr_addr = wr_addr_q;
    assign wr_en   = wr_en_q;
    assign done    = done_q;

endmodule
`default_nettype wire
